multi_adder_fifo: RTL



---
 rtl/multi_adder_fifo.sv | 111 +++++++++++
 1 files changed

// File: rtl/multi_adder_fifo.sv
// multi_adder_fifo: N-channel streaming adder; per-channel input FIFOs joined into
// one registered sum stage (optional saturation, overflow flag) feeding an output FIFO.
module multi_adder_fifo #(
    parameter int DW = 32,
    parameter int NUM_CH = 3,
    parameter int FIFO_DEPTH = 16,
    parameter bit SAT = 0,
    parameter int CNT_W = 32,
    localparam int OW = DW + $clog2(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [NUM_CH*DW-1:0] in_data,
    input  logic [NUM_CH-1:0]    in_valid,
    output logic [NUM_CH-1:0]    in_ready,
    output logic [OW-1:0]        out_data,
    output logic                 out_ovf,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT_W-1:0]     sum_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [NUM_CH-1:0]    empty_v;
    logic [NUM_CH*DW-1:0] heads;
    logic                 fire, drain, pipe_valid, pipe_ovf, ovf, o_full, o_push, o_pop;
    logic [OW-1:0]        pipe_data, full_sum, result;
    logic [OW:0]          o_mem [FIFO_DEPTH];
    logic [AW-1:0]        o_rp, o_wp;
    logic [AW:0]          o_cnt;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DW-1:0] mem [FIFO_DEPTH];
        logic [AW-1:0] rp, wp;
        logic [AW:0]   cnt;
        logic          push;
        assign in_ready[c] = cnt != (AW+1)'(FIFO_DEPTH);
        assign empty_v[c] = cnt == '0;
        assign heads[c*DW +: DW] = mem[rp];
        assign push = in_valid[c] & in_ready[c] & !flush;
        always_ff @(posedge clk) begin
            if (push) mem[wp] <= in_data[c*DW +: DW];
        end
        always_ff @(posedge clk or posedge rst) begin
            if (rst || flush) begin
                rp <= '0;
                wp <= '0;
                cnt <= '0;
            end else begin
                if (push) wp <= wp + 1'b1;
                if (fire) rp <= rp + 1'b1;
                cnt <= cnt + (AW+1)'(push) - (AW+1)'(fire);
            end
        end
    end

    always_comb begin
        full_sum = '0;
        for (int c = 0; c < NUM_CH; c++) full_sum = full_sum + OW'(heads[c*DW +: DW]);
    end

    assign ovf = |full_sum[OW-1:DW];
    assign result = (SAT && ovf) ? OW'({DW{1'b1}}) : full_sum;
    // the pipe may accept a new sum in the same cycle it hands its old one on
    assign drain = pipe_valid & !o_full;
    assign fire = (&(~empty_v)) & (!pipe_valid | drain) & !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= 1'b0;
            pipe_data <= '0;
            pipe_ovf <= 1'b0;
        end else if (flush) begin
            pipe_valid <= 1'b0;
        end else if (fire) begin
            pipe_valid <= 1'b1;
            pipe_data <= result;
            pipe_ovf <= ovf;
        end else if (drain) begin
            pipe_valid <= 1'b0;
        end
    end

    assign o_full = o_cnt == (AW+1)'(FIFO_DEPTH);
    assign out_valid = o_cnt != '0;
    assign o_push = drain & !flush;
    assign o_pop = out_valid & out_ready;
    assign {out_ovf, out_data} = out_valid ? o_mem[o_rp] : '0;

    always_ff @(posedge clk) begin
        if (o_push) o_mem[o_wp] <= {pipe_ovf, pipe_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            o_rp <= '0;
            o_wp <= '0;
            o_cnt <= '0;
        end else begin
            if (o_push) o_wp <= o_wp + 1'b1;
            if (o_pop) o_rp <= o_rp + 1'b1;
            o_cnt <= o_cnt + (AW+1)'(o_push) - (AW+1)'(o_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sum_cnt <= '0;
        else if (o_pop) sum_cnt <= sum_cnt + 1'b1;
    end
endmodule
